// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcode encodings, operand-select constants,
// issue-stage FSM states and the per-opcode EX occupancy function.
package alu_pkg;

   localparam int unsigned ALU_SEL_W  = 5;
   localparam int unsigned REG_ADDR_W = 5;

   localparam logic [ALU_SEL_W-1:0] ALU_ADD    = 5'd0;
   localparam logic [ALU_SEL_W-1:0] ALU_SUB    = 5'd1;
   localparam logic [ALU_SEL_W-1:0] ALU_SLL    = 5'd2;
   localparam logic [ALU_SEL_W-1:0] ALU_SRL    = 5'd3;
   localparam logic [ALU_SEL_W-1:0] ALU_SRA    = 5'd4;
   localparam logic [ALU_SEL_W-1:0] ALU_AND    = 5'd5;
   localparam logic [ALU_SEL_W-1:0] ALU_OR     = 5'd6;
   localparam logic [ALU_SEL_W-1:0] ALU_XOR    = 5'd7;
   localparam logic [ALU_SEL_W-1:0] ALU_MUL    = 5'd8;
   localparam logic [ALU_SEL_W-1:0] ALU_MULH   = 5'd9;
   localparam logic [ALU_SEL_W-1:0] ALU_MULHU  = 5'd10;
   localparam logic [ALU_SEL_W-1:0] ALU_MULHSU = 5'd11;
   localparam logic [ALU_SEL_W-1:0] ALU_DIV    = 5'd12;
   localparam logic [ALU_SEL_W-1:0] ALU_DIVU   = 5'd13;
   localparam logic [ALU_SEL_W-1:0] ALU_REM    = 5'd14;
   localparam logic [ALU_SEL_W-1:0] ALU_REMU   = 5'd15;
   localparam logic [ALU_SEL_W-1:0] ALU_SLT    = 5'd16;
   localparam logic [ALU_SEL_W-1:0] ALU_SLTU   = 5'd17;

   localparam logic OP1_RS1 = 1'b0;
   localparam logic OP1_PC  = 1'b1;
   localparam logic OP2_RS2 = 1'b0;
   localparam logic OP2_IMM = 1'b1;

   typedef enum logic [1:0] {
      ST_EMPTY  = 2'd0,
      ST_SETTLE = 2'd1,
      ST_DONE   = 2'd2
   } issue_state_e;

   // Cycles an opcode occupies EX before its ALU result may be sampled.
   function automatic int unsigned alu_latency(input logic [ALU_SEL_W-1:0] select,
                                               input int unsigned mul_cycles,
                                               input int unsigned div_cycles);
      if (select >= ALU_MUL && select <= ALU_MULHSU) return mul_cycles;
      if (select >= ALU_DIV && select <= ALU_REMU)   return div_cycles;
      return 1;
   endfunction

endpackage

// File: rtl/fwd_mux.sv
// Per-operand forwarding priority: EX/MEM over MEM/WB over register file.
// x0 is never forwarded.
// Ports: rs_addr/rf_data (source operand), exmem_* and memwb_* (forwarding
// sources), fwd_data_c (combinational forwarded value).
module fwd_mux
   import alu_pkg::*;
#(
   parameter int unsigned XLEN = 32
) (
   input  logic [REG_ADDR_W-1:0] rs_addr,
   input  logic [XLEN-1:0]       rf_data,
   input  logic [REG_ADDR_W-1:0] exmem_rd_addr,
   input  logic                  exmem_reg_write,
   input  logic [XLEN-1:0]       exmem_result,
   input  logic [REG_ADDR_W-1:0] memwb_rd_addr,
   input  logic                  memwb_reg_write,
   input  logic [XLEN-1:0]       memwb_result,
   output logic [XLEN-1:0]       fwd_data_c
);

   // Youngest in-flight producer wins.
   always_comb begin
      fwd_data_c = rf_data;
      if (rs_addr != '0) begin
         if (exmem_reg_write && (exmem_rd_addr == rs_addr)) begin
            fwd_data_c = exmem_result;
         end else if (memwb_reg_write && (memwb_rd_addr == rs_addr)) begin
            fwd_data_c = memwb_result;
         end
      end
   end

endmodule

// File: rtl/ex_issue_stage.sv
// ID/EX pipeline register and operand issue for the RV32IM ALU.
// Forwards rs1/rs2, selects operands and registers DATA1/DATA2/SELECT.
// MUL/DIV opcodes are held in EX for MUL_CYCLES/DIV_CYCLES cycles while
// decode is back-pressured through ID_READY.
// Ports: CLK/RESET (async active-low); ID_* decode instruction and handshake;
// EXMEM_*/MEMWB_* forwarding sources; STALL_IN/FLUSH control; DATA1, DATA2,
// SELECT to the ALU; EX_* registered stage state.
module ex_issue_stage
   import alu_pkg::*;
#(
   parameter int unsigned XLEN       = 32,
   parameter int unsigned MUL_CYCLES = 2,
   parameter int unsigned DIV_CYCLES = 4,
   parameter int unsigned CNT_W      = 3
) (
   input  logic                  CLK,
   input  logic                  RESET,
   input  logic                  ID_VALID,
   output logic                  ID_READY,
   input  logic [XLEN-1:0]       ID_PC,
   input  logic [XLEN-1:0]       ID_RS1_DATA,
   input  logic [XLEN-1:0]       ID_RS2_DATA,
   input  logic [REG_ADDR_W-1:0] ID_RS1_ADDR,
   input  logic [REG_ADDR_W-1:0] ID_RS2_ADDR,
   input  logic [REG_ADDR_W-1:0] ID_RD_ADDR,
   input  logic [XLEN-1:0]       ID_IMM,
   input  logic [ALU_SEL_W-1:0]  ID_ALU_SELECT,
   input  logic                  ID_OP1_SEL,
   input  logic                  ID_OP2_SEL,
   input  logic                  ID_REG_WRITE,
   input  logic [REG_ADDR_W-1:0] EXMEM_RD_ADDR,
   input  logic                  EXMEM_REG_WRITE,
   input  logic [XLEN-1:0]       EXMEM_RESULT,
   input  logic [REG_ADDR_W-1:0] MEMWB_RD_ADDR,
   input  logic                  MEMWB_REG_WRITE,
   input  logic [XLEN-1:0]       MEMWB_RESULT,
   input  logic                  STALL_IN,
   input  logic                  FLUSH,
   output logic [XLEN-1:0]       DATA1,
   output logic [XLEN-1:0]       DATA2,
   output logic [ALU_SEL_W-1:0]  SELECT,
   output logic                  EX_VALID,
   output logic                  EX_RESULT_VALID,
   output logic [XLEN-1:0]       EX_PC,
   output logic [XLEN-1:0]       EX_RS2_FWD,
   output logic [REG_ADDR_W-1:0] EX_RD_ADDR,
   output logic                  EX_REG_WRITE
);

   issue_state_e     state_q, state_n;
   logic [CNT_W-1:0] cnt_q, cnt_n;
   logic [CNT_W-1:0] lat_m1_c;
   logic             capture;
   logic             valid_n;
   logic             advance;
   logic [XLEN-1:0]  fwd_rs1_c, fwd_rs2_c;

   fwd_mux #(.XLEN(XLEN)) u_fwd_rs1 (
      .rs_addr         (ID_RS1_ADDR),
      .rf_data         (ID_RS1_DATA),
      .exmem_rd_addr   (EXMEM_RD_ADDR),
      .exmem_reg_write (EXMEM_REG_WRITE),
      .exmem_result    (EXMEM_RESULT),
      .memwb_rd_addr   (MEMWB_RD_ADDR),
      .memwb_reg_write (MEMWB_REG_WRITE),
      .memwb_result    (MEMWB_RESULT),
      .fwd_data_c      (fwd_rs1_c)
   );

   fwd_mux #(.XLEN(XLEN)) u_fwd_rs2 (
      .rs_addr         (ID_RS2_ADDR),
      .rf_data         (ID_RS2_DATA),
      .exmem_rd_addr   (EXMEM_RD_ADDR),
      .exmem_reg_write (EXMEM_REG_WRITE),
      .exmem_result    (EXMEM_RESULT),
      .memwb_rd_addr   (MEMWB_RD_ADDR),
      .memwb_reg_write (MEMWB_REG_WRITE),
      .memwb_result    (MEMWB_RESULT),
      .fwd_data_c      (fwd_rs2_c)
   );

   // Handshake is combinational so decode sees the hold in the same cycle.
   assign advance  = !STALL_IN && (cnt_q == '0);
   assign ID_READY = advance && !FLUSH;
   assign lat_m1_c = CNT_W'(alu_latency(ID_ALU_SELECT, MUL_CYCLES, DIV_CYCLES) - 1);

   // State register.
   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         state_q <= ST_EMPTY;
         cnt_q   <= '0;
      end else begin
         state_q <= state_n;
         cnt_q   <= cnt_n;
      end
   end

   // Next state: flush beats countdown, countdown ignores STALL_IN.
   always_comb begin
      state_n = state_q;
      cnt_n   = cnt_q;
      valid_n = EX_VALID;
      capture = 1'b0;
      if (FLUSH) begin
         state_n = ST_EMPTY;
         cnt_n   = '0;
         valid_n = 1'b0;
      end else begin
         unique case (state_q)
            ST_SETTLE: begin
               cnt_n = cnt_q - CNT_W'(1);
               if (cnt_q == CNT_W'(1)) state_n = ST_DONE;
            end
            default: begin
               if (!STALL_IN) begin
                  if (ID_VALID) begin
                     capture = 1'b1;
                     valid_n = 1'b1;
                     cnt_n   = lat_m1_c;
                     state_n = (lat_m1_c == '0) ? ST_DONE : ST_SETTLE;
                  end else begin
                     valid_n = 1'b0;
                     state_n = ST_EMPTY;
                  end
               end
            end
         endcase
      end
   end

   // EX payload; data fields only move on capture.
   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         EX_VALID        <= 1'b0;
         EX_RESULT_VALID <= 1'b0;
         DATA1           <= '0;
         DATA2           <= '0;
         SELECT          <= '0;
         EX_PC           <= '0;
         EX_RS2_FWD      <= '0;
         EX_RD_ADDR      <= '0;
         EX_REG_WRITE    <= 1'b0;
      end else begin
         EX_VALID        <= valid_n;
         EX_RESULT_VALID <= valid_n && (cnt_n == '0);
         if (capture) begin
            DATA1        <= (ID_OP1_SEL == OP1_PC)  ? ID_PC  : fwd_rs1_c;
            DATA2        <= (ID_OP2_SEL == OP2_IMM) ? ID_IMM : fwd_rs2_c;
            SELECT       <= ID_ALU_SELECT;
            EX_PC        <= ID_PC;
            EX_RS2_FWD   <= fwd_rs2_c;
            EX_RD_ADDR   <= ID_RD_ADDR;
            EX_REG_WRITE <= ID_REG_WRITE;
         end
      end
   end

endmodule

// File: tb/tb_ex_issue_stage.sv
// Scoreboard bench for ex_issue_stage: expected EX payloads are queued at
// capture and compared when EX_RESULT_VALID shows a settled result.
module tb_ex_issue_stage;
   import alu_pkg::*;

   typedef struct packed {
      logic [31:0] d1;
      logic [31:0] d2;
      logic [31:0] rs2;
      logic [31:0] pc;
      logic [4:0]  sel;
      logic [4:0]  rd;
      logic        we;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        id_valid = 1'b0;
   logic        id_ready;
   logic [31:0] id_pc = '0, id_rs1_data = '0, id_rs2_data = '0, id_imm = '0;
   logic [4:0]  id_rs1_addr = '0, id_rs2_addr = '0, id_rd_addr = '0;
   logic [4:0]  id_alu_select = '0;
   logic        id_op1_sel = 1'b0, id_op2_sel = 1'b0, id_reg_write = 1'b0;
   logic [4:0]  exmem_rd_addr = '0, memwb_rd_addr = '0;
   logic        exmem_reg_write = 1'b0, memwb_reg_write = 1'b0;
   logic [31:0] exmem_result = '0, memwb_result = '0;
   logic        stall_in = 1'b0, flush = 1'b0;
   logic [31:0] data1, data2, ex_pc, ex_rs2_fwd;
   logic [4:0]  select, ex_rd_addr;
   logic        ex_valid, ex_result_valid, ex_reg_write;

   int   n_checks = 0;
   int   n_fail   = 0;
   int   n_pushed = 0;
   int   n_pops   = 0;
   exp_t q[$];
   exp_t held;

   ex_issue_stage #(.XLEN(32), .MUL_CYCLES(2), .DIV_CYCLES(4), .CNT_W(3)) dut (
      .CLK(clk), .RESET(rst_n),
      .ID_VALID(id_valid), .ID_READY(id_ready), .ID_PC(id_pc),
      .ID_RS1_DATA(id_rs1_data), .ID_RS2_DATA(id_rs2_data),
      .ID_RS1_ADDR(id_rs1_addr), .ID_RS2_ADDR(id_rs2_addr), .ID_RD_ADDR(id_rd_addr),
      .ID_IMM(id_imm), .ID_ALU_SELECT(id_alu_select),
      .ID_OP1_SEL(id_op1_sel), .ID_OP2_SEL(id_op2_sel), .ID_REG_WRITE(id_reg_write),
      .EXMEM_RD_ADDR(exmem_rd_addr), .EXMEM_REG_WRITE(exmem_reg_write), .EXMEM_RESULT(exmem_result),
      .MEMWB_RD_ADDR(memwb_rd_addr), .MEMWB_REG_WRITE(memwb_reg_write), .MEMWB_RESULT(memwb_result),
      .STALL_IN(stall_in), .FLUSH(flush),
      .DATA1(data1), .DATA2(data2), .SELECT(select),
      .EX_VALID(ex_valid), .EX_RESULT_VALID(ex_result_valid),
      .EX_PC(ex_pc), .EX_RS2_FWD(ex_rs2_fwd), .EX_RD_ADDR(ex_rd_addr), .EX_REG_WRITE(ex_reg_write)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_instr(input logic [4:0] sel, input logic [4:0] rs1a, input logic [31:0] rs1d,
                            input logic [4:0] rs2a, input logic [31:0] rs2d, input logic [31:0] imm,
                            input logic op1, input logic op2, input logic [31:0] pc,
                            input logic [4:0] rd);
      id_alu_select = sel;  id_rs1_addr = rs1a; id_rs1_data = rs1d;
      id_rs2_addr   = rs2a; id_rs2_data = rs2d; id_imm      = imm;
      id_op1_sel    = op1;  id_op2_sel  = op2;  id_pc       = pc;
      id_rd_addr    = rd;   id_reg_write = 1'b1;
   endtask

   task automatic no_fwd();
      exmem_reg_write = 1'b0; memwb_reg_write = 1'b0;
      exmem_rd_addr = '0; memwb_rd_addr = '0;
   endtask

   // Present the current instruction, capture it, and optionally walk the hold window.
   task automatic issue(input logic [31:0] e_d1, input logic [31:0] e_d2, input logic [31:0] e_rs2,
                        input int lat, input bit wait_done);
      exp_t e;
      id_valid = 1'b1;
      #1;
      check("ready_before_capture", 32'(id_ready), 32'd1);
      e.d1 = e_d1; e.d2 = e_d2; e.rs2 = e_rs2; e.pc = id_pc;
      e.sel = id_alu_select; e.rd = id_rd_addr; e.we = id_reg_write;
      step();
      q.push_back(e);
      n_pushed++;
      held = e;
      id_valid = 1'b0;
      if (wait_done) begin
         for (int i = 0; i < lat - 1; i++) begin
            check("hold_ready", 32'(id_ready), 32'd0);
            check("hold_result_valid", 32'(ex_result_valid), 32'd0);
            step();
         end
         check("settled_result_valid", 32'(ex_result_valid), 32'd1);
         check("settled_ready", 32'(id_ready), 32'd1);
      end
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_data1"},  data1, 32'd0);
      check({tag, "_data2"},  data2, 32'd0);
      check({tag, "_select"}, 32'(select), 32'd0);
      check({tag, "_valid"},  32'(ex_valid), 32'd0);
      check({tag, "_rvalid"}, 32'(ex_result_valid), 32'd0);
      check({tag, "_pc"},     ex_pc, 32'd0);
      check({tag, "_rs2"},    ex_rs2_fwd, 32'd0);
      check({tag, "_rd"},     32'(ex_rd_addr), 32'd0);
      check({tag, "_we"},     32'(ex_reg_write), 32'd0);
   endtask

   // Scoreboard: compare the oldest expected entry when a settled result appears.
   always @(negedge clk) begin
      if (rst_n && ex_result_valid && q.size() > 0) begin
         exp_t e;
         e = q.pop_front();
         n_pops++;
         check("sb_data1",  data1, e.d1);
         check("sb_data2",  data2, e.d2);
         check("sb_rs2fwd", ex_rs2_fwd, e.rs2);
         check("sb_pc",     ex_pc, e.pc);
         check("sb_select", 32'(select), 32'(e.sel));
         check("sb_rd",     32'(ex_rd_addr), 32'(e.rd));
         check("sb_we",     32'(ex_reg_write), 32'(e.we));
         check("sb_valid",  32'(ex_valid), 32'd1);
      end
   end

   initial begin
      #2;
      check_all_zero("reset");
      step();
      step();
      @(negedge clk);
      rst_n = 1'b1;
      step();

      // Plain ADD, no hazards.
      no_fwd();
      set_instr(ALU_ADD, 5'd1, 32'd5, 5'd2, 32'd7, 32'd0, OP1_RS1, OP2_RS2, 32'h100, 5'd10);
      issue(32'd5, 32'd7, 32'd7, 1, 1'b1);

      // rs1 forwarding priority.
      exmem_rd_addr = 5'd3; exmem_reg_write = 1'b1; exmem_result = 32'h11;
      memwb_rd_addr = 5'd3; memwb_reg_write = 1'b1; memwb_result = 32'h22;
      set_instr(ALU_ADD, 5'd3, 32'h33, 5'd4, 32'h44, 32'd0, OP1_RS1, OP2_RS2, 32'h104, 5'd11);
      issue(32'h11, 32'h44, 32'h44, 1, 1'b1);
      exmem_reg_write = 1'b0;
      set_instr(ALU_ADD, 5'd3, 32'h33, 5'd4, 32'h44, 32'd0, OP1_RS1, OP2_RS2, 32'h108, 5'd12);
      issue(32'h22, 32'h44, 32'h44, 1, 1'b1);
      exmem_rd_addr = 5'd0; exmem_reg_write = 1'b1;
      memwb_rd_addr = 5'd0; memwb_reg_write = 1'b1;
      set_instr(ALU_ADD, 5'd0, 32'h55, 5'd4, 32'h44, 32'd0, OP1_RS1, OP2_RS2, 32'h10c, 5'd13);
      issue(32'h55, 32'h44, 32'h44, 1, 1'b1);

      // rs2 forwarded to store data while PC/imm feed the ALU.
      exmem_rd_addr = 5'd5; exmem_reg_write = 1'b1; exmem_result = 32'h77;
      memwb_rd_addr = 5'd6; memwb_reg_write = 1'b1; memwb_result = 32'h88;
      set_instr(ALU_SUB, 5'd6, 32'h66, 5'd5, 32'h99, 32'h12, OP1_PC, OP2_IMM, 32'h200, 5'd14);
      issue(32'h200, 32'h12, 32'h77, 1, 1'b1);
      no_fwd();

      // DIV holds EX for four cycles, then back-to-back pass-through select 20.
      set_instr(ALU_DIV, 5'd7, 32'h64, 5'd8, 32'h5, 32'd0, OP1_RS1, OP2_RS2, 32'h300, 5'd15);
      issue(32'h64, 32'h5, 32'h5, 4, 1'b1);
      set_instr(5'd20, 5'd9, 32'hA5A5_0001, 5'd10, 32'h5A5A_0002, 32'd0, OP1_RS1, OP2_RS2, 32'h304, 5'd16);
      issue(32'hA5A5_0001, 32'h5A5A_0002, 32'h5A5A_0002, 1, 1'b1);

      // MUL, then a two-cycle downstream stall in DONE.
      set_instr(ALU_MUL, 5'd11, 32'h1234, 5'd12, 32'h10, 32'd0, OP1_RS1, OP2_RS2, 32'h308, 5'd17);
      issue(32'h1234, 32'h10, 32'h10, 2, 1'b1);
      stall_in = 1'b1;
      set_instr(ALU_XOR, 5'd13, 32'hF0F0, 5'd14, 32'h0F0F, 32'd0, OP1_RS1, OP2_RS2, 32'h30c, 5'd18);
      id_valid = 1'b1;
      #1;
      check("stall_ready", 32'(id_ready), 32'd0);
      for (int i = 0; i < 2; i++) begin
         step();
         check("stall_data1",  data1, held.d1);
         check("stall_data2",  data2, held.d2);
         check("stall_select", 32'(select), 32'(ALU_MUL));
         check("stall_valid",  32'(ex_valid), 32'd1);
         check("stall_ready_hold", 32'(id_ready), 32'd0);
      end
      stall_in = 1'b0;
      issue(32'hF0F0, 32'h0F0F, 32'h0F0F, 1, 1'b1);

      // Bubble drops EX_VALID.
      step();
      check("bubble_valid",  32'(ex_valid), 32'd0);
      check("bubble_rvalid", 32'(ex_result_valid), 32'd0);

      // FLUSH during DIV settle with a valid decode instruction.
      set_instr(ALU_REM, 5'd15, 32'h40, 5'd16, 32'h3, 32'd0, OP1_RS1, OP2_RS2, 32'h400, 5'd19);
      issue(32'h40, 32'h3, 32'h3, 4, 1'b0);
      flush = 1'b1;
      set_instr(ALU_ADD, 5'd17, 32'hDEAD, 5'd18, 32'hBEEF, 32'd0, OP1_RS1, OP2_RS2, 32'h404, 5'd20);
      id_valid = 1'b1;
      #1;
      check("flush_ready", 32'(id_ready), 32'd0);
      step();
      flush = 1'b0;
      id_valid = 1'b0;
      q.delete();
      n_pushed--;
      check("flush_valid",  32'(ex_valid), 32'd0);
      check("flush_rvalid", 32'(ex_result_valid), 32'd0);
      check("flush_select_kept", 32'(select), 32'(ALU_REM));
      #1;
      check("flush_cnt_zero_ready", 32'(id_ready), 32'd1);
      step();
      check("post_flush_valid", 32'(ex_valid), 32'd0);

      // Asynchronous reset mid-settle, then ADDI with imm = -1.
      set_instr(ALU_DIVU, 5'd19, 32'h99, 5'd20, 32'h7, 32'd0, OP1_RS1, OP2_RS2, 32'h500, 5'd21);
      issue(32'h99, 32'h7, 32'h7, 4, 1'b0);
      step();
      #2;
      rst_n = 1'b0;
      #1;
      check_all_zero("async_reset");
      q.delete();
      n_pushed--;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      step();
      set_instr(ALU_ADD, 5'd1, 32'd3, 5'd2, 32'd9, 32'hFFFF_FFFF, OP1_RS1, OP2_IMM, 32'h600, 5'd22);
      issue(32'd3, 32'hFFFF_FFFF, 32'd9, 1, 1'b1);

      step();
      step();
      check("sb_drained", 32'(q.size()), 32'd0);
      check("sb_pop_count", 32'(n_pops), 32'(n_pushed));
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
